// File: rtl/fixed_pkg.sv
// Shared fixed-point vertex format, scheduler state encoding and helpers.
package fixed_pkg;

  localparam int unsigned FIXED_W = 32;
  localparam int unsigned FRAC_W  = 16;

  // Signed Q16.16 scalar; a vertex is {z, y, x} with x at index 0.
  typedef logic signed [FIXED_W-1:0] fixed_t;
  typedef fixed_t [2:0] fixed3_t;

  typedef enum logic [2:0] {
    StIdle,
    StRange,
    StStart,
    StAck,
    StWait,
    StDone
  } raster_sched_state;

  // Integer part rounded toward minus infinity.
  function automatic logic signed [FIXED_W-1:0] ftoi_floor(input fixed_t f);
    return f >>> FRAC_W;
  endfunction

endpackage

// File: rtl/raster_tile_scheduler_if.sv
// Triangle-side and rasterizer-side signals of the tile scheduler.
// master: triangle source plus rasterizer; slave: the scheduler itself.
interface raster_tile_scheduler_if;
  import fixed_pkg::*;

  logic        tri_valid;
  logic        tri_ready;
  fixed3_t     vertex0;
  fixed3_t     vertex1;
  fixed3_t     vertex2;
  logic        rast_start;
  logic        rast_ready;
  fixed3_t     rast_vertex0;
  fixed3_t     rast_vertex1;
  fixed3_t     rast_vertex2;
  logic [12:0] rast_offset_x;
  logic [12:0] rast_offset_y;
  logic        busy;
  logic        tri_done;

  modport master (
    output tri_valid, vertex0, vertex1, vertex2, rast_ready,
    input  tri_ready, rast_start, rast_vertex0, rast_vertex1, rast_vertex2,
    input  rast_offset_x, rast_offset_y, busy, tri_done
  );

  modport slave (
    input  tri_valid, vertex0, vertex1, vertex2, rast_ready,
    output tri_ready, rast_start, rast_vertex0, rast_vertex1, rast_vertex2,
    output rast_offset_x, rast_offset_y, busy, tri_done
  );

endinterface

// File: rtl/raster_tile_scheduler_tile_bbox.sv
// tile_bbox: combinational vertex bounding box -> clamped tile index range.
// Used only when RASTER_TILE_BBOX_CULL_EN is defined.
module tile_bbox
  import fixed_pkg::*;
#(
  parameter logic [12:0] SCREEN_W = 13'd160,
  parameter logic [12:0] SCREEN_H = 13'd120,
  parameter logic [12:0] TILE_W   = 13'd64,
  parameter logic [12:0] TILE_H   = 13'd64
) (
  input  fixed_t      vx0,
  input  fixed_t      vy0,
  input  fixed_t      vx1,
  input  fixed_t      vy1,
  input  fixed_t      vx2,
  input  fixed_t      vy2,
  output logic [12:0] tx0,
  output logic [12:0] tx1,
  output logic [12:0] ty0,
  output logic [12:0] ty1,
  output logic        empty
);

  localparam int unsigned TXS = $clog2(TILE_W);
  localparam int unsigned TYS = $clog2(TILE_H);

  function automatic logic signed [31:0] min3(input logic signed [31:0] a,
                                              input logic signed [31:0] b,
                                              input logic signed [31:0] c);
    logic signed [31:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [31:0] max3(input logic signed [31:0] a,
                                              input logic signed [31:0] b,
                                              input logic signed [31:0] c);
    logic signed [31:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Clamp a pixel coordinate into [0, lim-1].
  function automatic logic [12:0] clamp_axis(input logic signed [31:0] v,
                                             input logic [12:0] lim);
    if (v < 0) return 13'd0;
    if (v >= $signed(32'(lim))) return lim - 13'd1;
    return v[12:0];
  endfunction

  logic signed [31:0] xmin, xmax, ymin, ymax;
  logic [12:0]        xlo, xhi, ylo, yhi;

  // Bounding box, emptiness test and conversion to tile indices.
  always_comb begin
    xmin  = min3(ftoi_floor(vx0), ftoi_floor(vx1), ftoi_floor(vx2));
    xmax  = max3(ftoi_floor(vx0), ftoi_floor(vx1), ftoi_floor(vx2));
    ymin  = min3(ftoi_floor(vy0), ftoi_floor(vy1), ftoi_floor(vy2));
    ymax  = max3(ftoi_floor(vy0), ftoi_floor(vy1), ftoi_floor(vy2));
    empty = (xmax < 0) || (xmin >= $signed(32'(SCREEN_W))) ||
            (ymax < 0) || (ymin >= $signed(32'(SCREEN_H)));
    xlo   = clamp_axis(xmin, SCREEN_W);
    xhi   = clamp_axis(xmax, SCREEN_W);
    ylo   = clamp_axis(ymin, SCREEN_H);
    yhi   = clamp_axis(ymax, SCREEN_H);
    tx0   = xlo >> TXS;
    tx1   = xhi >> TXS;
    ty0   = ylo >> TYS;
    ty1   = yhi >> TYS;
  end

endmodule

// File: rtl/raster_tile_scheduler.sv
// raster_tile_scheduler: accepts one triangle, then runs the fixed-tile rasterizer
// once per tile of its tile range in raster order and pulses tri_done at the end.
// Optional RASTER_TILE_BBOX_CULL_EN: restrict the range to the vertex bounding box;
// otherwise every triangle covers the full screen.
module raster_tile_scheduler
  import fixed_pkg::*;
#(
  parameter logic [12:0] SCREEN_W = 13'd160,
  parameter logic [12:0] SCREEN_H = 13'd120,
  parameter logic [12:0] TILE_W   = 13'd64,
  parameter logic [12:0] TILE_H   = 13'd64
) (
  input logic                    clk,
  input logic                    rstn,
  raster_tile_scheduler_if.slave bus
);

  localparam int unsigned TXS = $clog2(TILE_W);
  localparam int unsigned TYS = $clog2(TILE_H);

  raster_sched_state state_q, state_d;
  fixed3_t           vtx0_q, vtx0_d, vtx1_q, vtx1_d, vtx2_q, vtx2_d;
  logic [12:0]       tx0_q, tx0_d, tx1_q, tx1_d, ty0_q, ty0_d, ty1_q, ty1_d;
  logic [12:0]       tx_q, tx_d, ty_q, ty_d;
  logic [12:0]       off_x_q, off_x_d, off_y_q, off_y_d;
  logic              start_q;

  logic [12:0]       rng_tx0, rng_tx1, rng_ty0, rng_ty1;
  logic              rng_empty;
  logic              last_tile;

`ifdef RASTER_TILE_BBOX_CULL_EN
  tile_bbox #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .TILE_W   (TILE_W),
    .TILE_H   (TILE_H)
  ) u_tile_bbox (
    .vx0   (vtx0_q[0]),
    .vy0   (vtx0_q[1]),
    .vx1   (vtx1_q[0]),
    .vy1   (vtx1_q[1]),
    .vx2   (vtx2_q[0]),
    .vy2   (vtx2_q[1]),
    .tx0   (rng_tx0),
    .tx1   (rng_tx1),
    .ty0   (rng_ty0),
    .ty1   (rng_ty1),
    .empty (rng_empty)
  );
`else
  assign rng_tx0   = 13'd0;
  assign rng_tx1   = (SCREEN_W - 13'd1) >> TXS;
  assign rng_ty0   = 13'd0;
  assign rng_ty1   = (SCREEN_H - 13'd1) >> TYS;
  assign rng_empty = 1'b0;
`endif

  assign last_tile = (tx_q == tx1_q) && (ty_q == ty1_q);

  // Next-state, latched vertices, tile walk and offsets for the next START.
  always_comb begin
    state_d = state_q;
    vtx0_d  = vtx0_q;
    vtx1_d  = vtx1_q;
    vtx2_d  = vtx2_q;
    tx0_d   = tx0_q;
    tx1_d   = tx1_q;
    ty0_d   = ty0_q;
    ty1_d   = ty1_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    off_x_d = off_x_q;
    off_y_d = off_y_q;
    unique case (state_q)
      StIdle: begin
        if (bus.tri_valid) begin
          vtx0_d  = bus.vertex0;
          vtx1_d  = bus.vertex1;
          vtx2_d  = bus.vertex2;
          state_d = StRange;
        end
      end
      StRange: begin
        tx0_d = rng_tx0;
        tx1_d = rng_tx1;
        ty0_d = rng_ty0;
        ty1_d = rng_ty1;
        tx_d  = rng_tx0;
        ty_d  = rng_ty0;
        if (rng_empty) begin
          state_d = StDone;
        end else begin
          off_x_d = rng_tx0 << TXS;
          off_y_d = rng_ty0 << TYS;
          state_d = StStart;
        end
      end
      StStart: state_d = StAck;
      StAck: begin
        // Low ready confirms the rasterizer took the start.
        if (!bus.rast_ready) state_d = StWait;
      end
      StWait: begin
        if (bus.rast_ready) begin
          if (last_tile) begin
            state_d = StDone;
          end else begin
            if (tx_q == tx1_q) begin
              tx_d = tx0_q;
              ty_d = ty_q + 13'd1;
            end else begin
              tx_d = tx_q + 13'd1;
            end
            off_x_d = tx_d << TXS;
            off_y_d = ty_d << TYS;
            state_d = StStart;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      vtx0_q  <= '0;
      vtx1_q  <= '0;
      vtx2_q  <= '0;
      tx0_q   <= '0;
      tx1_q   <= '0;
      ty0_q   <= '0;
      ty1_q   <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      off_x_q <= '0;
      off_y_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vtx0_q  <= vtx0_d;
      vtx1_q  <= vtx1_d;
      vtx2_q  <= vtx2_d;
      tx0_q   <= tx0_d;
      tx1_q   <= tx1_d;
      ty0_q   <= ty0_d;
      ty1_q   <= ty1_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      off_x_q <= off_x_d;
      off_y_q <= off_y_d;
      // Registered one-cycle pulse, high in the cycle after START.
      start_q <= (state_q == StStart);
    end
  end

  assign bus.tri_ready     = (state_q == StIdle);
  assign bus.busy          = (state_q != StIdle);
  assign bus.tri_done      = (state_q == StDone);
  assign bus.rast_start    = start_q;
  assign bus.rast_vertex0  = vtx0_q;
  assign bus.rast_vertex1  = vtx1_q;
  assign bus.rast_vertex2  = vtx2_q;
  assign bus.rast_offset_x = off_x_q;
  assign bus.rast_offset_y = off_y_q;

endmodule

// File: tb/tb_raster_tile_scheduler.sv
// Directed table-driven bench for raster_tile_scheduler with a rasterizer model.
module tb_raster_tile_scheduler;
  import fixed_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  raster_tile_scheduler_if bus ();

  raster_tile_scheduler dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    fixed3_t     v0;
    fixed3_t     v1;
    fixed3_t     v2;
    int          n;
    logic [12:0] ox[6];
    logic [12:0] oy[6];
  } vec_t;

  vec_t tbl[3];

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int st_n[$];
  int st_x[$];
  int st_y[$];
  int dn[$];
  int ac[$];
  int rise_n = 0;
  int fall_dly = 1;
  int run_cyc = 5;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic fixed3_t mk(input int x, input int y);
    fixed3_t v;
    v[0] = x * 65536;
    v[1] = y * 65536;
    v[2] = '0;
    return v;
  endfunction

  // Monitor sampled mid-cycle, then rasterizer model drives rast_ready.
  initial begin
    int  phase;
    int  cnt;
    bit  pending;
    bit  saw_low;
    bit  prev_start;
    phase = 0; cnt = 0; pending = 0; saw_low = 0; prev_start = 0;
    bus.rast_ready = 1'b1;
    forever begin
      @(negedge clk);
      ncyc++;
      chk("ready_vs_busy", int'(bus.tri_ready), int'(!bus.busy));
      if (!rstn) begin
        phase = 0; pending = 0; saw_low = 0; prev_start = 0;
        bus.rast_ready = 1'b1;
      end else begin
        if (bus.rast_start) begin
          chk("start_width", int'(prev_start), 0);
          chk("reissue", int'(pending), 0);
          st_n.push_back(ncyc);
          st_x.push_back(int'(bus.rast_offset_x));
          st_y.push_back(int'(bus.rast_offset_y));
          pending = 1; saw_low = 0;
        end
        if (pending && !bus.rast_ready) saw_low = 1;
        if (pending && saw_low && bus.rast_ready) pending = 0;
        prev_start = bus.rast_start;
        if (bus.tri_done) dn.push_back(ncyc);
        if (bus.tri_valid && bus.tri_ready) ac.push_back(ncyc);
        case (phase)
          0: if (bus.rast_start) begin cnt = fall_dly; phase = 1; end
          1: begin
            cnt--;
            if (cnt <= 0) begin bus.rast_ready = 1'b0; cnt = run_cyc; phase = 2; end
          end
          default: begin
            cnt--;
            if (cnt <= 0) begin bus.rast_ready = 1'b1; rise_n = ncyc; phase = 0; end
          end
        endcase
      end
    end
  end

  task automatic clear_logs();
    st_n.delete(); st_x.delete(); st_y.delete(); dn.delete(); ac.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int idx);
    int start;
    int k;
    start = ac.size();
    bus.vertex0 = tbl[idx].v0;
    bus.vertex1 = tbl[idx].v1;
    bus.vertex2 = tbl[idx].v2;
    bus.tri_valid = 1'b1;
    k = 0;
    while (ac.size() == start && k < 200) begin tick(); k++; end
    bus.tri_valid = 1'b0;
    chk("accept", ac.size(), start + 1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (dn.size() < target && k < budget) begin tick(); k++; end
  endtask

  task automatic run_tri(input int idx);
    int n;
    n = tbl[idx].n;
    clear_logs();
    send(idx);
    wait_done(1, 8 * (fall_dly + run_cyc + 10) + 50);
    repeat (5) tick();
    chk("tri_done_count", dn.size(), 1);
    chk("start_count", st_n.size(), n);
    for (int i = 0; i < n && i < st_n.size(); i++) begin
      chk($sformatf("offset_x[%0d]", i), st_x[i], int'(tbl[idx].ox[i]));
      chk($sformatf("offset_y[%0d]", i), st_y[i], int'(tbl[idx].oy[i]));
    end
    for (int i = 1; i < st_n.size(); i++)
      chk($sformatf("start_gap[%0d]", i), st_n[i] - st_n[i-1], fall_dly + run_cyc + 2);
    if (dn.size() > 0 && ac.size() > 0) begin
      if (n > 0) begin
        if (st_n.size() > 0) chk("start_latency", st_n[0] - ac[0], 3);
        chk("done_after_rise", dn[0] - rise_n, 1);
      end else begin
        chk("empty_done_latency", dn[0] - ac[0], 2);
      end
    end
  endtask

  initial begin
    logic [12:0] full_x[6];
    logic [12:0] full_y[6];
    int k;
    for (int i = 0; i < 6; i++) begin
      full_x[i] = 13'((i % 3) * 64);
      full_y[i] = 13'((i / 3) * 64);
    end
    tbl[0].v0 = mk(10, 10);  tbl[0].v1 = mk(50, 10);  tbl[0].v2 = mk(10, 50);
    tbl[1].v0 = mk(60, 60);  tbl[1].v1 = mk(130, 60); tbl[1].v2 = mk(60, 100);
    tbl[2].v0 = mk(-20, 10); tbl[2].v1 = mk(-5, 10);  tbl[2].v2 = mk(-20, 40);
    for (int t = 0; t < 3; t++) begin
      tbl[t].ox = full_x;
      tbl[t].oy = full_y;
      tbl[t].n  = 6;
    end
`ifdef RASTER_TILE_BBOX_CULL_EN
    tbl[0].n = 1;
    tbl[2].n = 0;
`endif

    bus.tri_valid = 1'b0;
    bus.vertex0 = '0;
    bus.vertex1 = '0;
    bus.vertex2 = '0;

    // Reset values while rstn is held low.
    repeat (3) tick();
    chk("rst_tri_ready", int'(bus.tri_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_rast_start", int'(bus.rast_start), 0);
    chk("rst_tri_done", int'(bus.tri_done), 0);
    chk("rst_offset_x", int'(bus.rast_offset_x), 0);
    chk("rst_offset_y", int'(bus.rast_offset_y), 0);
    chk("rst_vertex0_x", longint'(bus.rast_vertex0[0]), 0);
    rstn = 1'b1;
    repeat (2) tick();

    for (int t = 0; t < 3; t++) run_tri(t);

    // Slow rasterizer: ready falls 3 cycles after start, rises 4096 later.
    fall_dly = 3;
    run_cyc  = 4096;
    run_tri(0);
    chk("latched_vertex1_x", longint'(bus.rast_vertex1[0]), 50 * 65536);
    fall_dly = 1;
    run_cyc  = 5;

    // Reset while waiting on the second tile.
    run_cyc = 50;
    clear_logs();
    send(1);
    k = 0;
    while (st_n.size() < 2 && k < 500) begin tick(); k++; end
    chk("midrun_second_start", st_n.size(), 2);
    repeat (10) tick();
    rstn = 1'b0;
    tick();
    chk("midrun_tri_ready", int'(bus.tri_ready), 1);
    chk("midrun_busy", int'(bus.busy), 0);
    chk("midrun_rast_start", int'(bus.rast_start), 0);
    chk("midrun_tri_done", int'(bus.tri_done), 0);
    rstn = 1'b1;
    run_cyc = 5;
    tick();
    run_tri(1);

    // Back-to-back: tri_valid held high across DONE.
    clear_logs();
    bus.vertex0 = tbl[1].v0;
    bus.vertex1 = tbl[1].v1;
    bus.vertex2 = tbl[1].v2;
    bus.tri_valid = 1'b1;
    k = 0;
    while (ac.size() < 2 && k < 1000) begin tick(); k++; end
    bus.tri_valid = 1'b0;
    chk("b2b_accepts", ac.size(), 2);
    wait_done(2, 1000);
    repeat (5) tick();
    chk("b2b_done_count", dn.size(), 2);
    if (ac.size() >= 2 && dn.size() >= 1) chk("b2b_accept_gap", ac[1] - dn[0], 1);
    chk("b2b_starts", st_n.size(), 2 * tbl[1].n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
